guess_row_plotter: RTL and testbench

- Downstream consumer of the square offset counters in the Mastermind draw path.
- On a start request, draws one guess row of 4 pegs, each a 20x20 filled square, and drives VGA-adapter plot signals.
- Each peg gets its own latched colour.
- Converts per-square pixel offsets into absolute screen coordinates.
- Sits between the game-logic FSM (start/done handshake) and the vga_adapter (x, y, colour, plot).

---
 rtl/mm_draw_pkg.sv | 37 +++
 rtl/guess_row_plotter_if.sv | 29 ++
 rtl/square_offset_counter.sv | 41 ++++
 rtl/guess_row_plotter.sv | 91 +++++++++
 tb/tb_guess_row_plotter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_draw_pkg.sv
// Shared draw-path constants, screen geometry, FSM states
// and a peg-colour select helper for the Mastermind board.
package mm_draw_pkg;

  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam int COLOUR_W  = 3;
  localparam int X_W       = $clog2(SCREEN_W);
  localparam int Y_W       = $clog2(SCREEN_H);

  localparam int SQ_SIZE   = 20;
  localparam int NUM_PEGS  = 4;
  localparam int NUM_ROWS  = 10;
  localparam int COL_X0    = 40;
  localparam int COL_PITCH = 24;
  localparam int ROW_Y0    = 10;
  localparam int ROW_PITCH = 22;

  localparam int OFS_W     = $clog2(SQ_SIZE);
  localparam int PEG_W     = $clog2(NUM_PEGS);
  localparam int ROW_W     = $clog2(NUM_ROWS);
  localparam int COLS_W    = NUM_PEGS * COLOUR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [COLOUR_W-1:0] peg_colour(
    input logic [COLS_W-1:0] cols,
    input logic [PEG_W-1:0]  p
  );
    return cols[COLOUR_W*p +: COLOUR_W];
  endfunction

endpackage

// File: rtl/guess_row_plotter_if.sv
// Start/done request bus plus VGA plot outputs of the row plotter.
// master: game FSM side (drives start/row/colours); slave: plotter.
interface guess_row_plotter_if;
  import mm_draw_pkg::*;

  logic                start;
  logic [ROW_W-1:0]    row;
  logic [COLS_W-1:0]   colours;
  logic                busy;
  logic                done;
  logic                err;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                plot;

  modport master (
    output start, row, colours,
    input  busy, done, err,
    input  vga_x, vga_y, vga_colour, plot
  );

  modport slave (
    input  start, row, colours,
    output busy, done, err,
    output vga_x, vga_y, vga_colour, plot
  );

endinterface

// File: rtl/square_offset_counter.sv
// Raster dx/dy offsets inside one peg square; last flags (19,19).
// Ports: clock, resetn, clr, en in; dx, dy, last out.
module square_offset_counter
  import mm_draw_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  output logic [OFS_W-1:0] dx,
  output logic [OFS_W-1:0] dy,
  output logic             last
);

  localparam logic [OFS_W-1:0] EDGE = OFS_W'(SQ_SIZE - 1);

  logic dx_end;
  logic dy_end;

  assign dx_end = (dx == EDGE);
  assign dy_end = (dy == EDGE);
  assign last   = dx_end && dy_end;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dx <= '0;
      dy <= '0;
    end else if (clr) begin
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      if (dx_end) begin
        dx <= '0;
        dy <= dy_end ? '0 : dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/guess_row_plotter.sv
// Draws one guess row of 4 filled 20x20 pegs as VGA plot writes.
// Ports: clock, resetn; bus (slave): start/row/colours -> busy/done/err/plot/x/y/colour.
module guess_row_plotter
  import mm_draw_pkg::*;
(
  input logic                 clock,
  input logic                 resetn,
  guess_row_plotter_if.slave  bus
);

  state_t              state;
  logic [PEG_W-1:0]    peg;
  logic [COLS_W-1:0]   cols_q;
  logic [Y_W-1:0]      y_base;
  logic [OFS_W-1:0]    dx;
  logic [OFS_W-1:0]    dy;
  logic                sq_last;
  logic                cnt_clr;
  logic                cnt_en;

  assign cnt_clr = (state == ST_IDLE);
  assign cnt_en  = (state == ST_DRAW);

  square_offset_counter u_ofs (
    .clock  (clock),
    .resetn (resetn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .dx     (dx),
    .dy     (dy),
    .last   (sq_last)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      peg            <= '0;
      cols_q         <= '0;
      y_base         <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.plot       <= 1'b0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          bus.plot <= 1'b0;
          if (bus.start) begin
            if (bus.row < ROW_W'(NUM_ROWS)) begin
              cols_q   <= bus.colours;
              // row top edge is fixed for the whole draw
              y_base   <= Y_W'(ROW_Y0)
                        + Y_W'(bus.row) * Y_W'(ROW_PITCH);
              peg      <= '0;
              bus.busy <= 1'b1;
              state    <= ST_DRAW;
            end else begin
              bus.err  <= 1'b1;
            end
          end
        end
        ST_DRAW: begin
          bus.plot       <= 1'b1;
          bus.vga_x      <= X_W'(COL_X0)
                          + X_W'(peg) * X_W'(COL_PITCH)
                          + X_W'(dx);
          bus.vga_y      <= y_base + Y_W'(dy);
          bus.vga_colour <= peg_colour(cols_q, peg);
          if (sq_last) begin
            peg <= peg + 1'b1;
            if (peg == PEG_W'(NUM_PEGS - 1))
              state <= ST_DONE;
          end
        end
        ST_DONE: begin
          bus.plot <= 1'b0;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_row_plotter.sv
// Self-checking bench for guess_row_plotter: spec-point table,
// reference pixel model, error/reset/back-to-back sequences.
module tb_guess_row_plotter;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic [3:0]  row;
    logic [11:0] cols;
    int          idx;
    int          x;
    int          y;
    int          c;
  } vec_t;

  logic clock;
  logic resetn;

  guess_row_plotter_if bus();

  guess_row_plotter dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int   n_cmp;
  int   n_bad;
  pix_t cap [0:1599];
  int   ncap;
  int   done_at;
  int   busy_gap;
  vec_t vt [$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: pixel i of a row, from peg/raster arithmetic.
  function automatic pix_t ref_pix(input int r,
                                   input logic [11:0] c,
                                   input int i);
    pix_t p;
    int pg, rem;
    pg  = i / 400;
    rem = i % 400;
    p.x = 9'(40 + pg * 24 + rem % 20);
    p.y = 8'(10 + r * 22 + rem / 20);
    p.c = 3'((c >> (3 * pg)) & 12'd7);
    return p;
  endfunction

  task automatic start_req(input logic [3:0] r, input logic [11:0] c);
    bus.start   = 1'b1;
    bus.row     = r;
    bus.colours = c;
    tick();
    bus.start   = 1'b0;
  endtask

  // Watch outputs after edges k+1..k+budget; optional start poke
  // held over t in [pf, pt] with row pr / colours pc.
  task automatic capture(input int budget, input int pf, input int pt,
                         input logic [3:0] pr, input logic [11:0] pc);
    ncap     = 0;
    done_at  = -1;
    busy_gap = 0;
    for (int t = 1; t <= budget && done_at < 0; t++) begin
      tick();
      if (bus.plot) begin
        if (ncap < 1600)
          cap[ncap] = '{x: bus.vga_x, y: bus.vga_y, c: bus.vga_colour};
        ncap++;
        if (!bus.busy) busy_gap++;
      end
      if (bus.done) done_at = t;
      if (t >= pf && t <= pt) begin
        bus.start   = 1'b1;
        bus.row     = pr;
        bus.colours = pc;
      end else begin
        bus.start   = 1'b0;
      end
    end
  endtask

  task automatic compare_run(input string tag, input int r,
                             input logic [11:0] c);
    int   bad;
    int   first;
    pix_t e;
    bad   = 0;
    first = -1;
    chk({tag, " plot_count"}, ncap, 1600);
    chk({tag, " done_cycle"}, done_at, 1601);
    chk({tag, " busy_during_plot"}, busy_gap, 0);
    for (int i = 0; i < ncap && i < 1600; i++) begin
      e = ref_pix(r, c, i);
      if (cap[i] !== e) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0) begin
      e = ref_pix(r, c, first);
      $display("  %s first bad pixel %0d: (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
               tag, first, cap[first].x, cap[first].y, cap[first].c,
               e.x, e.y, e.c);
    end
    chk({tag, " pixel_errors"}, bad, 0);
  endtask

  task automatic table_check(input logic [3:0] r, input logic [11:0] c);
    foreach (vt[j]) begin
      if (vt[j].row == r && vt[j].cols == c && vt[j].idx < ncap) begin
        chk($sformatf("vec%0d x", j), cap[vt[j].idx].x, vt[j].x);
        chk($sformatf("vec%0d y", j), cap[vt[j].idx].y, vt[j].y);
        chk($sformatf("vec%0d c", j), cap[vt[j].idx].c, vt[j].c);
      end
    end
  endtask

  task automatic full_run(input string tag, input logic [3:0] r,
                          input logic [11:0] c);
    start_req(r, c);
    chk({tag, " busy_after_accept"}, bus.busy, 1);
    capture(1700, -1, -1, 4'd0, 12'd0);
    compare_run(tag, r, c);
    table_check(r, c);
    chk({tag, " busy_at_done"}, bus.busy, 0);
    chk({tag, " plot_at_done"}, bus.plot, 0);
    tick();
    chk({tag, " done_one_cycle"}, bus.done, 0);
  endtask

  initial begin
    int          pc;
    int          dc;
    int          ec;
    logic [3:0]  r;
    logic [11:0] c;

    n_cmp = 0;
    n_bad = 0;
    vt.push_back('{4'd0, 12'o7421, 0,    40,  10,  1});
    vt.push_back('{4'd0, 12'o7421, 19,   59,  10,  1});
    vt.push_back('{4'd0, 12'o7421, 20,   40,  11,  1});
    vt.push_back('{4'd0, 12'o7421, 400,  64,  10,  2});
    vt.push_back('{4'd0, 12'o7421, 1599, 131, 29,  7});
    vt.push_back('{4'd9, 12'o1234, 0,    40,  208, 4});
    vt.push_back('{4'd9, 12'o1234, 19,   59,  208, 4});
    vt.push_back('{4'd9, 12'o1234, 1599, 131, 227, 1});

    resetn      = 1'b0;
    bus.start   = 1'b0;
    bus.row     = 4'd0;
    bus.colours = 12'd0;
    repeat (3) tick();
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst err", bus.err, 0);
    chk("rst plot", bus.plot, 0);
    chk("rst x", bus.vga_x, 0);
    chk("rst y", bus.vga_y, 0);
    chk("rst colour", bus.vga_colour, 0);
    resetn = 1'b1;
    tick();

    full_run("row0", 4'd0, 12'o7421);
    full_run("row9", 4'd9, 12'o1234);

    // out-of-range rows
    foreach (vt[j]) begin end
    for (int k = 10; k <= 15; k += 5) begin
      bus.start = 1'b1;
      bus.row   = 4'(k);
      tick();
      bus.start = 1'b0;
      chk($sformatf("row%0d err", k), bus.err, 1);
      chk($sformatf("row%0d busy", k), bus.busy, 0);
      chk($sformatf("row%0d plot", k), bus.plot, 0);
      pc = 0; dc = 0; ec = 0;
      for (int t = 0; t < 20; t++) begin
        tick();
        if (bus.plot) pc++;
        if (bus.done) dc++;
        if (bus.err)  ec++;
      end
      chk($sformatf("row%0d err_pulse_len", k), ec, 0);
      chk($sformatf("row%0d no_plot", k), pc, 0);
      chk($sformatf("row%0d no_done", k), dc, 0);
    end

    // start while busy, new row/colours: must be ignored
    start_req(4'd3, 12'o5163);
    capture(1700, 501, 503, 4'd7, 12'o2222);
    compare_run("poke", 3, 12'o5163);
    tick();

    // reset mid-draw
    start_req(4'd5, 12'o3456);
    for (int t = 0; t < 800; t++) tick();
    resetn = 1'b0;
    tick();
    chk("midrst plot", bus.plot, 0);
    chk("midrst busy", bus.busy, 0);
    chk("midrst x", bus.vga_x, 0);
    chk("midrst y", bus.vga_y, 0);
    chk("midrst done", bus.done, 0);
    resetn = 1'b1;
    pc = 0; dc = 0;
    for (int t = 0; t < 1700; t++) begin
      tick();
      if (bus.plot) pc++;
      if (bus.done) dc++;
    end
    chk("midrst no_plot", pc, 0);
    chk("midrst no_done", dc, 0);
    start_req(4'd2, 12'o6017);
    capture(1700, -1, -1, 4'd0, 12'd0);
    compare_run("after_rst", 2, 12'o6017);
    chk("after_rst x0", cap[0].x, 40);
    chk("after_rst y0", cap[0].y, 54);
    tick();

    // back-to-back: start in DONE ignored, next IDLE cycle accepted
    start_req(4'd1, 12'o1357);
    capture(1700, 1600, 1601, 4'd4, 12'o7654);
    compare_run("b2b_a", 1, 12'o1357);
    tick();
    bus.start = 1'b0;
    chk("b2b_b busy_after_accept", bus.busy, 1);
    capture(1700, -1, -1, 4'd0, 12'd0);
    compare_run("b2b_b", 4, 12'o7654);
    tick();

    // randomized rows/colours against the reference model
    for (int n = 0; n < 4; n++) begin
      r = 4'($urandom_range(0, 9));
      c = 12'($urandom());
      start_req(r, c);
      capture(1700, -1, -1, 4'd0, 12'd0);
      compare_run($sformatf("rand%0d", n), int'(r), c);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
